// File: rtl/cdce_readback_pkg.sv
// Shared definitions for the CDCE register readback controller: word geometry,
// read command nibble, FSM state encoding and the command word builder.
package cdce_readback_pkg;

    localparam int         CDCE_WORD_WIDTH = 32;
    localparam logic [3:0] CDCE_READ_CMD   = 4'hE;
    localparam int         CDCE_CNT_WIDTH  = 6;

    typedef logic [CDCE_WORD_WIDTH-1:0] cdce_word_t;
    typedef logic [CDCE_CNT_WIDTH-1:0]  cdce_cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        GAP,
        READ,
        DONE
    } cdce_state_e;

    // Read request: address in bits [7:4], read opcode in the low nibble.
    function automatic cdce_word_t cdce_read_cmd_word(input logic [3:0] addr);
        return {24'h0, addr, CDCE_READ_CMD};
    endfunction

endpackage

// File: rtl/cdce_shift_reg.sv
// LSB-first shift register shared by the transmit and receive phases:
// parallel load, serial in at the MSB end, serial out is q[0].
module cdce_shift_reg
    import cdce_readback_pkg::*;
#(
    parameter int WIDTH = CDCE_WORD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values of its neighbours; = here would collapse the chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_value;
        end else if (shift_en) begin
            q <= {serial_in, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/cdce_readback.sv
// CDCE SPI register readback: shifts a 32-bit read command out, idles cs_n for
// GAP_CYCLES, then shifts the 32-bit register word in and pulses read_valid.
module cdce_readback
    import cdce_readback_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_read,
    input  logic [3:0]  reg_addr,
    input  logic        miso,
    output logic        cs_n,
    output logic        mosi,
    output logic        busy,
    output logic [31:0] read_data,
    output logic        read_valid
);

    localparam cdce_cnt_t WORD_LAST = CDCE_CNT_WIDTH'(CDCE_WORD_WIDTH - 1);
    localparam cdce_cnt_t GAP_LAST  = CDCE_CNT_WIDTH'(GAP_CYCLES - 1);

    cdce_state_e state;
    cdce_cnt_t   cnt;
    logic        tx_en;

    cdce_word_t  sr_q;
    cdce_word_t  rx_word;
    logic        sr_load;
    logic        sr_shift;
    logic        sr_serial_in;

    // Loading the command word on the start edge is what latches reg_addr.
    assign sr_load      = (state == IDLE) && start_read;
    assign sr_shift     = (state == CMD) || (state == READ);
    assign sr_serial_in = (state == READ) && miso;

    // Word as it will stand after the final READ shift, captured in the same edge.
    assign rx_word = {miso, sr_q[CDCE_WORD_WIDTH-1:1]};

    // tx_en is a flop, so mosi is the AND of two registers and is forced low
    // outside CMD regardless of what the shared shift register holds.
    assign mosi = tx_en & sr_q[0];

    cdce_shift_reg #(
        .WIDTH (CDCE_WORD_WIDTH)
    ) u_shift_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (sr_load),
        .load_value (cdce_read_cmd_word(reg_addr)),
        .shift_en   (sr_shift),
        .serial_in  (sr_serial_in),
        .q          (sr_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cs_n       <= 1'b1;
            tx_en      <= 1'b0;
            busy       <= 1'b0;
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            read_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_read) begin
                        state <= CMD;
                        cs_n  <= 1'b0;
                        tx_en <= 1'b1;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                CMD: begin
                    if (cnt == WORD_LAST) begin
                        state <= GAP;
                        cs_n  <= 1'b1;
                        tx_en <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= READ;
                        cs_n  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ: begin
                    if (cnt == WORD_LAST) begin
                        state      <= DONE;
                        cs_n       <= 1'b1;
                        read_valid <= 1'b1;
                        read_data  <= rx_word;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cs_n  <= 1'b1;
                    tx_en <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdce_readback.sv
// Self-checking bench for cdce_readback: a CDCE device model drives miso from a
// scoreboard queue and checks the captured command and returned word.
module tb_cdce_readback;

    localparam int G = 2;

    typedef struct packed {
        logic [31:0] cmd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_read = 1'b0;
    logic [3:0]  reg_addr = 4'h0;
    logic        miso = 1'b0;
    logic        cs_n, mosi, busy, read_valid;
    logic [31:0] read_data;

    logic        start1 = 1'b0;
    logic [3:0]  reg_addr1 = 4'h0;
    logic        miso1 = 1'b1;
    logic        cs_n1, mosi1, busy1, read_valid1;
    logic [31:0] read_data1;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] cap = '0;
    int          lc = 0;
    logic        prev_rv = 1'b0;

    always #5 clk = ~clk;

    cdce_readback #(.GAP_CYCLES(G)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_read (start_read),
        .reg_addr   (reg_addr),
        .miso       (miso),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .busy       (busy),
        .read_data  (read_data),
        .read_valid (read_valid)
    );

    cdce_readback #(.GAP_CYCLES(1)) dut_gap1 (
        .clk        (clk),
        .reset      (reset),
        .start_read (start1),
        .reg_addr   (reg_addr1),
        .miso       (miso1),
        .cs_n       (cs_n1),
        .mosi       (mosi1),
        .busy       (busy1),
        .read_data  (read_data1),
        .read_valid (read_valid1)
    );

    function automatic logic [31:0] cmd_of(input logic [3:0] a);
        return {24'h0, a, 4'hE};
    endfunction

    // CDCE model and scoreboard: first 32 cs_n-low cycles capture mosi, next 32
    // present the expected word on miso; read_valid pops and compares.
    always @(negedge clk) begin
        if (reset) begin
            lc = 0;
            prev_rv = 1'b0;
        end else begin
            if (!cs_n) begin
                if (lc < 32) cap[lc] = mosi;
                else if (exp_q.size() != 0) miso = exp_q[0].data[lc-32];
                lc++;
            end
            if (read_valid) begin
                checks++;
                if (prev_rv) begin
                    errors++;
                    $display("FAIL rv_width read_valid high two cycles running");
                end
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rv_unexpected read_data=%h with no transaction pending", read_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    checks += 2;
                    if (read_data !== mon_e.data) begin
                        errors++;
                        $display("FAIL sb_data got %h exp %h", read_data, mon_e.data);
                    end
                    if (cap !== mon_e.cmd) begin
                        errors++;
                        $display("FAIL sb_cmd got %h exp %h", cap, mon_e.cmd);
                    end
                end
                lc = 0;
            end
            if (cs_n && mosi) begin
                checks++;
                errors++;
                $display("FAIL mosi_idle mosi=1 while cs_n=1");
            end
            prev_rv = read_valid;
        end
    end

    task automatic pulse_start(input logic [3:0] a, input logic [31:0] d);
        exp_t e;
        e.cmd  = cmd_of(a);
        e.data = d;
        @(posedge clk);
        #1;
        reg_addr   = a;
        start_read = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 start_read = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start_read = 1'b1;
        start1     = 1'b1;
        reg_addr   = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cs_n, mosi, busy, read_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl got cs_n/mosi/busy/rv=%b exp 1000", {cs_n, mosi, busy, read_valid});
        end
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 00000000", read_data);
        end
        checks++;
        if ({cs_n1, busy1, read_valid1} !== 3'b100 || read_data1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_gap1 got %b/%h exp 100/00000000", {cs_n1, busy1, read_valid1}, read_data1);
        end
        @(posedge clk);
        #1;
        reset      = 1'b0;
        start_read = 1'b0;
        start1     = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b exp 0", busy);
        end
    endtask

    task automatic test_single_read();
        logic [31:0] cmd;
        logic [3:0]  exp_v;
        cmd = cmd_of(4'h3);
        pulse_start(4'h3, 32'h8184_0323);
        for (int k = 0; k <= 67; k++) begin
            @(negedge clk);
            exp_v[3] = (k < 32) ? 1'b0 : (k < 32 + G) ? 1'b1 : (k < 64 + G) ? 1'b0 : 1'b1;
            exp_v[2] = (k < 32) ? cmd[k] : 1'b0;
            exp_v[1] = (k <= 64 + G);
            exp_v[0] = (k == 64 + G);
            checks++;
            if ({cs_n, mosi, busy, read_valid} !== exp_v) begin
                errors++;
                $display("FAIL single_frame k=%0d cs_n/mosi/busy/rv got %b exp %b", k, {cs_n, mosi, busy, read_valid}, exp_v);
            end
            checks++;
            if (read_data !== ((k < 64 + G) ? 32'h0 : 32'h8184_0323)) begin
                errors++;
                $display("FAIL single_data k=%0d got %h", k, read_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  addrs[3];
        logic [31:0] words[3];
        logic [31:0] cmd;
        logic [3:0]  exp_v;
        exp_t        e;
        addrs = '{4'h1, 4'hA, 4'hC};
        words = '{32'hDEAD_BEEF, 32'h0000_0001, 32'h8000_0000};
        e.cmd  = cmd_of(addrs[0]);
        e.data = words[0];
        @(posedge clk);
        #1;
        reg_addr   = addrs[0];
        start_read = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            cmd = cmd_of(addrs[i]);
            for (int k = 0; k <= 67; k++) begin
                @(negedge clk);
                exp_v[3] = (k < 32) ? 1'b0 : (k < 32 + G) ? 1'b1 : (k < 64 + G) ? 1'b0 : 1'b1;
                exp_v[2] = (k < 32) ? cmd[k] : 1'b0;
                exp_v[1] = (k <= 64 + G);
                exp_v[0] = (k == 64 + G);
                checks++;
                if ({cs_n, mosi, busy, read_valid} !== exp_v) begin
                    errors++;
                    $display("FAIL b2b_frame txn=%0d k=%0d got %b exp %b", i, k, {cs_n, mosi, busy, read_valid}, exp_v);
                end
                if (k == 1) begin
                    if (i < 2) begin
                        reg_addr = addrs[i+1];
                        e.cmd    = cmd_of(addrs[i+1]);
                        e.data   = words[i+1];
                        exp_q.push_back(e);
                    end else begin
                        start_read = 1'b0;
                    end
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({cs_n, busy} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_stop cs_n/busy got %b exp 10", {cs_n, busy});
        end
    endtask

    task automatic test_ignore_start();
        pulse_start(4'h5, 32'hA5C3_0F12);
        for (int k = 0; k <= 70; k++) begin
            @(negedge clk);
            if (k == 40) begin
                reg_addr   = 4'h7;
                start_read = 1'b1;
            end
            if (k == 41) start_read = 1'b0;
            if (k == 64 + G) begin
                checks++;
                if (read_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL ignore_rv got %b exp 1", read_valid);
                end
            end
            if (k > 64 + G) begin
                checks++;
                if ({cs_n, busy} !== 2'b10) begin
                    errors++;
                    $display("FAIL ignore_idle k=%0d cs_n/busy got %b exp 10", k, {cs_n, busy});
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ignore_pending got %0d entries exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset_abort();
        int   rv_seen;
        logic done;
        exp_t e;
        rv_seen = 0;
        done    = 1'b0;
        pulse_start(4'h9, 32'h1234_5678);
        for (int k = 0; k <= 38; k++) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        e = exp_q.pop_front();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({cs_n, busy, read_valid} !== 3'b100) begin
            errors++;
            $display("FAIL abort_ctrl cs_n/busy/rv got %b exp 100", {cs_n, busy, read_valid});
        end
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_data got %h exp 00000000 (dropped %h)", read_data, e.data);
        end
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (read_valid) rv_seen++;
        end
        checks++;
        if (rv_seen != 0) begin
            errors++;
            $display("FAIL abort_rv got %0d pulses exp 0", rv_seen);
        end
        pulse_start(4'h2, 32'h0F0F_3C3C);
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL abort_restart timeout got %0d pending exp 0", exp_q.size());
        end
        checks++;
        if (read_data !== 32'h0F0F_3C3C) begin
            errors++;
            $display("FAIL abort_restart_data got %h exp 0f0f3c3c", read_data);
        end
    endtask

    task automatic test_gap1();
        logic [31:0] cmd;
        logic [2:0]  exp_v;
        cmd = cmd_of(4'h4);
        @(posedge clk);
        #1;
        reg_addr1 = 4'h4;
        start1    = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int k = 0; k <= 66; k++) begin
            @(negedge clk);
            exp_v[2] = (k < 32) ? 1'b0 : (k < 33) ? 1'b1 : (k < 65) ? 1'b0 : 1'b1;
            exp_v[1] = (k < 32) ? cmd[k] : 1'b0;
            exp_v[0] = (k == 65);
            checks++;
            if ({cs_n1, mosi1, read_valid1} !== exp_v) begin
                errors++;
                $display("FAIL gap1_frame k=%0d cs_n/mosi/rv got %b exp %b", k, {cs_n1, mosi1, read_valid1}, exp_v);
            end
            if (k == 64 || k == 65) begin
                checks++;
                if (read_data1 !== ((k == 65) ? 32'hFFFF_FFFF : 32'h0)) begin
                    errors++;
                    $display("FAIL gap1_data k=%0d got %h", k, read_data1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_gap1();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_pending got %0d entries exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
